// File: rtl/rv32_pkg.sv
// RV32I opcode constants, immediate-format enumeration and the ID/EX payload type
// shared by the decode stage and its immediate generator.
package rv32_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        regWe;
    logic        memRead;
    logic        illegal;
  } idex_t;

  function automatic logic isLegal(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_REG: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  function automatic logic usesRs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic logic usesRs2(input logic [6:0] op);
    return (op == OP_REG || op == OP_STORE || op == OP_BRANCH);
  endfunction

  function automatic logic writesRd(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_LOAD, OP_IMM, OP_REG: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// ID/EX payload channel: decode (master) presents a registered payload, EX (slave) consumes it.
interface id_stage_if;

  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic        ex_reg_we;
  logic        ex_mem_read;
  logic        ex_illegal;

  modport master (
    output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd,
           ex_opcode, ex_funct3, ex_funct7b5, ex_reg_we, ex_mem_read, ex_illegal,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd,
           ex_opcode, ex_funct3, ex_funct7b5, ex_reg_we, ex_mem_read, ex_illegal,
    output ex_ready
  );

endinterface

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; opcodes without an immediate yield zero.
module imm_gen
  import rv32_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  imm_type_t immType;
  logic      hasImm;

  always_comb begin
    hasImm  = 1'b1;
    immType = IMM_I;
    case (instr[6:0])
      OP_JALR, OP_LOAD, OP_IMM: immType = IMM_I;
      OP_STORE:                 immType = IMM_S;
      OP_BRANCH:                immType = IMM_B;
      OP_LUI, OP_AUIPC:         immType = IMM_U;
      OP_JAL:                   immType = IMM_J;
      default:                  hasImm  = 1'b0;
    endcase
  end

  always_comb begin
    imm = '0;
    if (hasImm) begin
      case (immType)
        IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
        IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        IMM_U:   imm = {instr[31:12], 12'h000};
        IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        default: imm = '0;
      endcase
    end
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: drives regfile read addresses and registers the ID/EX payload.
// Optional macro WB_BYPASS_EN forwards same-cycle writeback data into the operands.
module id_stage
  import rv32_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  output logic [4:0]      rf_addr_a,
  output logic [4:0]      rf_addr_b,
  input  logic [XLEN-1:0] rf_data_a,
  input  logic [XLEN-1:0] rf_data_b,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  id_stage_if.master      ex
);

  logic [6:0]  opcode_p0;
  logic [4:0]  rs1_p0;
  logic [4:0]  rs2_p0;
  logic [4:0]  rd_p0;
  logic        legal_p0;
  logic [31:0] imm_p0;
  logic [31:0] opA_p0;
  logic [31:0] opB_p0;
  idex_t       payNext_p0;

  idex_t       pay_p1;
  logic        vld_p1;

  logic        loadEn;
  logic        hazard;
  logic        take;

  // ---- p0: decode of the offered instruction ----
  assign opcode_p0 = if_instr[6:0];
  assign rd_p0     = if_instr[11:7];
  assign rs1_p0    = if_instr[19:15];
  assign rs2_p0    = if_instr[24:20];
  assign legal_p0  = isLegal(opcode_p0);

  assign rf_addr_a = rs1_p0;
  assign rf_addr_b = rs2_p0;

  imm_gen uImmGen (
    .instr (if_instr),
    .imm   (imm_p0)
  );

  // The regfile does not hide x0 or same-cycle writes, so both are resolved here.
  always_comb begin
    opA_p0 = rf_data_a;
    opB_p0 = rf_data_b;
`ifdef WB_BYPASS_EN
    if (wb_we && wb_addr != 5'd0 && wb_addr == rs1_p0) opA_p0 = wb_data;
    if (wb_we && wb_addr != 5'd0 && wb_addr == rs2_p0) opB_p0 = wb_data;
`endif
    if (rs1_p0 == 5'd0) opA_p0 = '0;
    if (rs2_p0 == 5'd0) opB_p0 = '0;
  end

`ifndef WB_BYPASS_EN
  logic unusedWb;
  assign unusedWb = ^{wb_we, wb_addr, wb_data};
`endif

  always_comb begin
    payNext_p0          = '0;
    payNext_p0.pc       = if_pc;
    payNext_p0.rs1Data  = opA_p0;
    payNext_p0.rs2Data  = opB_p0;
    payNext_p0.imm      = imm_p0;
    payNext_p0.rd       = rd_p0;
    payNext_p0.opcode   = opcode_p0;
    payNext_p0.funct3   = if_instr[14:12];
    payNext_p0.funct7b5 = if_instr[30];
    payNext_p0.regWe    = legal_p0 && writesRd(opcode_p0) && (rd_p0 != 5'd0);
    payNext_p0.memRead  = (opcode_p0 == OP_LOAD);
    payNext_p0.illegal  = !legal_p0;
  end

  // A load sitting in EX cannot supply its result to the very next instruction.
  always_comb begin
    hazard = vld_p1 && pay_p1.memRead && (pay_p1.rd != 5'd0) &&
             ((usesRs1(opcode_p0) && pay_p1.rd == rs1_p0) ||
              (usesRs2(opcode_p0) && pay_p1.rd == rs2_p0));
  end

  assign loadEn   = !vld_p1 || ex.ex_ready;
  assign if_ready = rst && (flush || (loadEn && !hazard));
  assign take     = if_valid && !flush && loadEn && !hazard;

  // ---- p1: registered ID/EX payload ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (loadEn) begin
      vld_p1 <= if_valid && !hazard;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pay_p1    <= '0;
      pay_p1.pc <= RESET_PC;
    end else if (take) begin
      pay_p1 <= payNext_p0;
    end
  end

  assign ex.ex_valid    = vld_p1;
  assign ex.ex_pc       = pay_p1.pc;
  assign ex.ex_rs1_data = pay_p1.rs1Data;
  assign ex.ex_rs2_data = pay_p1.rs2Data;
  assign ex.ex_imm      = pay_p1.imm;
  assign ex.ex_rd       = pay_p1.rd;
  assign ex.ex_opcode   = pay_p1.opcode;
  assign ex.ex_funct3   = pay_p1.funct3;
  assign ex.ex_funct7b5 = pay_p1.funct7b5;
  assign ex.ex_reg_we   = pay_p1.regWe;
  assign ex.ex_mem_read = pay_p1.memRead;
  assign ex.ex_illegal  = pay_p1.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios followed by randomized traffic against a
// behavioural model of the decode/handshake rules.
module tb_id_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [6:0] T_LUI = 7'h37, T_AUIPC = 7'h17, T_JAL = 7'h6F, T_JALR = 7'h67;
  localparam logic [6:0] T_BR = 7'h63, T_LD = 7'h03, T_ST = 7'h23, T_IMM = 7'h13, T_REG = 7'h33;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        we;
    logic        mr;
    logic        ill;
  } pay_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic [4:0]  rf_addr_a;
  logic [4:0]  rf_addr_b;
  logic [31:0] rf_data_a;
  logic [31:0] rf_data_b;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  id_stage_if exIf ();

  id_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .flush     (flush),
    .rf_addr_a (rf_addr_a),
    .rf_addr_b (rf_addr_b),
    .rf_data_a (rf_data_a),
    .rf_data_b (rf_data_b),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .ex        (exIf.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkPay(input string tag, input pay_t obs, input pay_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic pay_t got();
    return {exIf.ex_pc, exIf.ex_rs1_data, exIf.ex_rs2_data, exIf.ex_imm, exIf.ex_rd,
            exIf.ex_opcode, exIf.ex_funct3, exIf.ex_funct7b5, exIf.ex_reg_we,
            exIf.ex_mem_read, exIf.ex_illegal};
  endfunction

  function automatic logic legalOp(input logic [6:0] op);
    return op inside {T_LUI, T_AUIPC, T_JAL, T_JALR, T_BR, T_LD, T_ST, T_IMM, T_REG};
  endfunction

  function automatic logic readsRs1(input logic [6:0] op);
    return !(op inside {T_LUI, T_AUIPC, T_JAL});
  endfunction

  function automatic logic readsRs2(input logic [6:0] op);
    return op inside {T_REG, T_ST, T_BR};
  endfunction

  function automatic logic [31:0] refOperand(input logic [4:0] rs, input logic [31:0] rf,
                                             input logic wbWe, input logic [4:0] wbAddr,
                                             input logic [31:0] wbData);
    if (rs == 5'd0) return 32'h0;
    if (BYPASS && wbWe && wbAddr == rs) return wbData;
    return rf;
  endfunction

  function automatic pay_t refDecode(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic [31:0] rfa, input logic [31:0] rfb,
                                     input logic wbWe, input logic [4:0] wbAddr,
                                     input logic [31:0] wbData);
    pay_t p;
    logic [6:0] op;
    logic [31:0] sx;
    op = ins[6:0];
    sx = {32{ins[31]}};
    p.pc   = pc;
    p.rs1d = refOperand(ins[19:15], rfa, wbWe, wbAddr, wbData);
    p.rs2d = refOperand(ins[24:20], rfb, wbWe, wbAddr, wbData);
    case (op)
      T_LD, T_IMM, T_JALR: p.imm = (sx << 12) | 32'(ins[31:20]);
      T_ST:  p.imm = (sx << 12) | (32'(ins[31:25]) << 5) | 32'(ins[11:7]);
      T_BR:  p.imm = (sx << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      T_LUI, T_AUIPC: p.imm = {ins[31:12], 12'h000};
      T_JAL: p.imm = (sx << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      default: p.imm = 32'h0;
    endcase
    p.rd  = ins[11:7];
    p.op  = op;
    p.f3  = ins[14:12];
    p.f7  = ins[30];
    p.ill = !legalOp(op);
    p.we  = (op inside {T_LUI, T_AUIPC, T_JAL, T_JALR, T_LD, T_IMM, T_REG}) && (ins[11:7] != 5'd0);
    p.mr  = (op == T_LD);
    return p;
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] ins;
    logic [6:0] op;
    ins = $urandom;
    case ($urandom_range(0, 10))
      0: op = T_LUI;   1: op = T_AUIPC; 2: op = T_JAL;  3: op = T_JALR;
      4: op = T_BR;    5: op = T_LD;    6: op = T_ST;   7: op = T_IMM;
      8: op = T_REG;   9: op = 7'h7F;   default: op = T_LD;
    endcase
    ins[6:0]   = op;
    ins[11:7]  = 5'($urandom_range(0, 7));
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  initial begin
    pay_t snap;
    pay_t m;
    logic mv;
    logic hz;
    logic expRdy;
    logic [31:0] ins;

    rst = 1'b0; if_valid = 1'b1; if_instr = 32'hFFF00293; if_pc = 32'h10;
    flush = 1'b0; rf_data_a = 32'h1234; rf_data_b = 32'h5678;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0; exIf.ex_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(exIf.ex_valid), 32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    chkPay("rst_payload", got(), '{pc: RST_PC, default: '0});

    // addi x5,x0,-1
    rst = 1'b1;
    #1;
    chk("addi_if_ready", 32'(if_ready), 32'd1);
    chk("addi_rf_addr_b", 32'(rf_addr_b), 32'd31);
    tick();
    chk("addi_valid", 32'(exIf.ex_valid), 32'd1);
    chk("addi_imm", exIf.ex_imm, 32'hFFFF_FFFF);
    chk("addi_rd", 32'(exIf.ex_rd), 32'd5);
    chk("addi_we", 32'(exIf.ex_reg_we), 32'd1);
    chk("addi_pc", exIf.ex_pc, 32'h10);
    chk("addi_rs1_x0", exIf.ex_rs1_data, 32'h0);

    // lw x6,0(x1) then add x7,x6,x2
    if_instr = 32'h0000A303; if_pc = 32'h14; rf_data_a = 32'h1000;
    tick();
    chk("lw_memread", 32'(exIf.ex_mem_read), 32'd1);
    chk("lw_rs1", exIf.ex_rs1_data, 32'h1000);
    if_instr = 32'h002303B3; if_pc = 32'h18;
    #1;
    chk("lu_if_ready", 32'(if_ready), 32'd0);
    tick();
    chk("lu_bubble", 32'(exIf.ex_valid), 32'd0);
    #1;
    chk("lu_retry_ready", 32'(if_ready), 32'd1);
    tick();
    chk("lu_add_valid", 32'(exIf.ex_valid), 32'd1);
    chk("lu_add_pc", exIf.ex_pc, 32'h18);
    chk("lu_add_rd", 32'(exIf.ex_rd), 32'd7);

    // add x0,x0,x2 with garbage on port A
    if_instr = 32'h00200033; if_pc = 32'h1C; rf_data_a = 32'hDEAD;
    tick();
    chk("x0_rs1", exIf.ex_rs1_data, 32'h0);
    chk("x0_we", 32'(exIf.ex_reg_we), 32'd0);

    // addi x4,x3,0 with a same-cycle write to x3
    if_instr = 32'h00018213; if_pc = 32'h20; rf_data_a = 32'h11;
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h55;
    snap = refDecode(32'h00018213, 32'h20, 32'h11, rf_data_b, 1'b1, 5'd3, 32'h55);
    tick();
    chk("bypass_rs1", exIf.ex_rs1_data, BYPASS ? 32'h55 : 32'h11);
    wb_we = 1'b0;

    // back-pressure holds the payload
    exIf.ex_ready = 1'b0; if_instr = 32'hFFF00293; if_pc = 32'h40;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_if_ready", 32'(if_ready), 32'd0);
      tick();
      chk("stall_valid", 32'(exIf.ex_valid), 32'd1);
      chkPay("stall_payload", got(), snap);
    end
    flush = 1'b1;
    #1;
    chk("flush_if_ready", 32'(if_ready), 32'd1);
    tick();
    chk("flush_valid", 32'(exIf.ex_valid), 32'd0);
    flush = 1'b0; exIf.ex_ready = 1'b1;

    // illegal opcode 0x7F
    if_instr = 32'hFFFF_FFFF; if_pc = 32'h44;
    tick();
    chk("ill_valid", 32'(exIf.ex_valid), 32'd1);
    chk("ill_flag", 32'(exIf.ex_illegal), 32'd1);
    chk("ill_we", 32'(exIf.ex_reg_we), 32'd0);
    chk("ill_memread", 32'(exIf.ex_mem_read), 32'd0);

    // asynchronous reset mid-stream
    if_instr = 32'hFFF00293; if_pc = 32'h48;
    tick();
    chk("pre_rst_valid", 32'(exIf.ex_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(exIf.ex_valid), 32'd0);
    chk("async_rst_pc", exIf.ex_pc, RST_PC);
    chk("async_rst_if_ready", 32'(if_ready), 32'd0);
    tick();
    rst = 1'b1;

    // randomized traffic against the model
    mv = 1'b0;
    m = '{pc: RST_PC, default: '0};
    for (int cyc = 0; cyc < 600; cyc++) begin
      ins = randInstr();
      if_instr = ins;
      if_pc = $urandom;
      if_valid = ($urandom_range(0, 9) < 8);
      flush = ($urandom_range(0, 19) == 0);
      rf_data_a = $urandom; rf_data_b = $urandom;
      wb_we = 1'($urandom_range(0, 1)); wb_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
      exIf.ex_ready = ($urandom_range(0, 3) != 0);
      #1;
      hz = mv && m.mr && (m.rd != 5'd0) &&
           ((readsRs1(ins[6:0]) && m.rd == ins[19:15]) || (readsRs2(ins[6:0]) && m.rd == ins[24:20]));
      expRdy = flush || ((!mv || exIf.ex_ready) && !hz);
      chk("rnd_if_ready", 32'(if_ready), 32'(expRdy));
      chk("rnd_rf_addr", 32'({rf_addr_a, rf_addr_b}), 32'({ins[19:15], ins[24:20]}));
      if (flush) begin
        mv = 1'b0;
      end else if (!mv || exIf.ex_ready) begin
        if (hz || !if_valid) begin
          mv = 1'b0;
        end else begin
          mv = 1'b1;
          m = refDecode(ins, if_pc, rf_data_a, rf_data_b, wb_we, wb_addr, wb_data);
        end
      end
      tick();
      chk("rnd_valid", 32'(exIf.ex_valid), 32'(mv));
      if (mv) chkPay("rnd_payload", got(), m);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
